xor_checksum_accum: RTL

//  Streaming XOR checksum/parity engine: the clocked, parametrised successor of the 2-input XOR gate.

---
 rtl/xor_checksum_accum.sv | 87 ++++++++
 1 files changed

// File: rtl/xor_checksum_accum.sv
// Streaming XOR checksum / parity engine: folds a packet of beats into one running XOR
// and presents the result with a saturating beat count on a valid/ready output port.
module xor_checksum_accum #(
  parameter int WIDTH = 8,
  parameter int MODE  = 0,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inValid,
  output logic             inReady,
  input  logic [WIDTH-1:0] inData,
  input  logic             inLast,
  input  logic             inClear,
  output logic             outValid,
  input  logic             outReady,
  output logic [WIDTH-1:0] outSum,
  output logic [CNT_W-1:0] outCount
);

  typedef enum logic {ACCUM, HOLD} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           state;
  logic [WIDTH-1:0] acc;
  logic [CNT_W-1:0] count;
  logic [WIDTH-1:0] nextAcc;
  logic [CNT_W-1:0] nextCount;
  logic [WIDTH-1:0] foldSum;
  logic             accept;

  // A clear wins over the beat presented in the same cycle, so the beat is refused.
  assign inReady = (state == ACCUM) && !inClear;
  assign accept  = inValid && inReady;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    nextAcc   = acc ^ inData;
    nextCount = (count == CNT_MAX) ? count : count + CNT_W'(1);
    foldSum   = '0;
    if (MODE == 1) foldSum[0] = ^nextAcc;
    else           foldSum    = nextAcc;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ACCUM;
      acc      <= '0;
      count    <= '0;
      outValid <= 1'b0;
      outSum   <= '0;
      outCount <= '0;
    end else begin
      case (state)
        ACCUM: begin
          if (inClear) begin
            acc   <= '0;
            count <= '0;
          end else if (accept) begin
            if (inLast) begin
              outSum   <= foldSum;
              outCount <= nextCount;
              outValid <= 1'b1;
              acc      <= '0;
              count    <= '0;
              state    <= HOLD;
            end else begin
              acc   <= nextAcc;
              count <= nextCount;
            end
          end
        end
        HOLD: begin
          // Result stays frozen until the consumer takes it; new input waits a cycle.
          if (outReady) begin
            outValid <= 1'b0;
            state    <= ACCUM;
          end
        end
        default: state <= ACCUM;
      endcase
    end
  end

endmodule
